// File: rtl/timestamp_word_assembler.sv
// timestamp_word_assembler
// This module pops tagged 32-bit words from a first-word-fall-through FIFO.
// It rebuilds each three-word hit record into a 64-bit timestamp and an
// 8-bit extra field, and offers the result on a valid/ready port.
// Words with a foreign identifier are counted in a saturating counter.
// Out-of-order words are counted in a second saturating counter.
module timestamp_word_assembler #(
    parameter logic [3:0] IDENTIFIER    = 4'b0101,
    parameter int         ERR_CNT_WIDTH = 16
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic                     FIFO_EMPTY,
    input  logic [31:0]              FIFO_DATA,
    output logic                     FIFO_READ,
    output logic                     TS_VALID,
    input  logic                     TS_READY,
    output logic [63:0]              TS_DATA,
    output logic [7:0]               TS_EXTRA,
    input  logic                     CLEAR_ERR,
    output logic [ERR_CNT_WIDTH-1:0] ID_ERR_CNT,
    output logic [ERR_CNT_WIDTH-1:0] SEQ_ERR_CNT
);

    typedef enum logic [1:0] {
        WAIT0 = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;
    state_t base_state;

    // The lower and middle fields of a partial record are kept apart from
    // the output registers. This keeps TS_DATA stable while a new record
    // is being collected.
    logic [23:0] lo_reg;
    logic [23:0] mid_reg;
    logic [63:0] ts_reg;
    logic [7:0]  extra_reg;

    logic rd;
    logic load_lo;
    logic load_mid;
    logic load_out;

    // Index 0 is the identifier error counter; index 1 is the sequence error counter.
    logic [1:0]               err_inc;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_reg [2];

    logic [3:0]  word_id;
    logic [3:0]  word_idx;
    logic [23:0] word_payload;

    assign word_id      = FIFO_DATA[31:28];
    assign word_idx     = FIFO_DATA[27:24];
    assign word_payload = FIFO_DATA[23:0];

    // Next-state logic: a HOLD that is handshaken this cycle acts as WAIT0,
    // so a word popped in the same cycle starts the next record.
    always_comb begin
        base_state = state_reg;
        state_next = state_reg;
        err_inc    = 2'b00;
        load_lo    = 1'b0;
        load_mid   = 1'b0;
        load_out   = 1'b0;
        rd         = !FIFO_EMPTY && ((state_reg != HOLD) || TS_READY);

        if ((state_reg == HOLD) && TS_READY) begin
            base_state = WAIT0;
        end
        state_next = base_state;

        if (rd) begin
            if (word_id != IDENTIFIER) begin
                err_inc[0] = 1'b1;
            end else begin
                case (base_state)
                    WAIT0: begin
                        if (word_idx == 4'd0) begin
                            load_lo    = 1'b1;
                            state_next = WAIT1;
                        end else begin
                            err_inc[1] = 1'b1;
                        end
                    end
                    WAIT1: begin
                        if (word_idx == 4'd1) begin
                            load_mid   = 1'b1;
                            state_next = WAIT2;
                        end else if (word_idx == 4'd0) begin
                            err_inc[1] = 1'b1;
                            load_lo    = 1'b1;
                            state_next = WAIT1;
                        end else begin
                            err_inc[1] = 1'b1;
                            state_next = WAIT0;
                        end
                    end
                    WAIT2: begin
                        if (word_idx == 4'd2) begin
                            load_out   = 1'b1;
                            state_next = HOLD;
                        end else if (word_idx == 4'd0) begin
                            err_inc[1] = 1'b1;
                            load_lo    = 1'b1;
                            state_next = WAIT1;
                        end else begin
                            err_inc[1] = 1'b1;
                            state_next = WAIT0;
                        end
                    end
                    default: begin
                        // In HOLD, rd is high only when TS_READY is high.
                        // In that case base_state is already WAIT0.
                        state_next = base_state;
                    end
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_reg <= WAIT0;
        end else begin
            state_reg <= state_next;
        end
    end

    // Partial-record and output field registers.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            lo_reg    <= '0;
            mid_reg   <= '0;
            ts_reg    <= '0;
            extra_reg <= '0;
        end else begin
            if (load_lo) begin
                lo_reg <= word_payload;
            end
            if (load_mid) begin
                mid_reg <= word_payload;
            end
            if (load_out) begin
                ts_reg    <= {word_payload[15:0], mid_reg, lo_reg};
                extra_reg <= word_payload[23:16];
            end
        end
    end

    // Saturating error counters. A clear overrides an increment in the same cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
        always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
            if (BUS_RST) begin
                err_cnt_reg[gi] <= '0;
            end else if (CLEAR_ERR) begin
                err_cnt_reg[gi] <= '0;
            end else if (err_inc[gi] && (err_cnt_reg[gi] != {ERR_CNT_WIDTH{1'b1}})) begin
                err_cnt_reg[gi] <= err_cnt_reg[gi] + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign FIFO_READ   = rd;
    assign TS_VALID    = (state_reg == HOLD);
    assign TS_DATA     = ts_reg;
    assign TS_EXTRA    = extra_reg;
    assign ID_ERR_CNT  = err_cnt_reg[0];
    assign SEQ_ERR_CNT = err_cnt_reg[1];

endmodule

// File: tb/tb_timestamp_word_assembler.sv
// Directed testbench for timestamp_word_assembler.
// A record-level reference model tracks which parts of a record are present,
// the pending records, and the error counts. The DUT is checked against it
// on every falling edge. Literal checks at chosen points pin the model.
module tb_timestamp_word_assembler;

    logic        BUS_CLK;
    logic        BUS_RST;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic        FIFO_READ;
    logic        TS_VALID;
    logic        TS_READY;
    logic [63:0] TS_DATA;
    logic [7:0]  TS_EXTRA;
    logic        CLEAR_ERR;
    logic [15:0] ID_ERR_CNT;
    logic [15:0] SEQ_ERR_CNT;

    timestamp_word_assembler #(
        .IDENTIFIER    (4'b0101),
        .ERR_CNT_WIDTH (16)
    ) dut (
        .BUS_CLK     (BUS_CLK),
        .BUS_RST     (BUS_RST),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .FIFO_DATA   (FIFO_DATA),
        .FIFO_READ   (FIFO_READ),
        .TS_VALID    (TS_VALID),
        .TS_READY    (TS_READY),
        .TS_DATA     (TS_DATA),
        .TS_EXTRA    (TS_EXTRA),
        .CLEAR_ERR   (CLEAR_ERR),
        .ID_ERR_CNT  (ID_ERR_CNT),
        .SEQ_ERR_CNT (SEQ_ERR_CNT)
    );

    initial begin
        BUS_CLK = 1'b0;
        forever #5 BUS_CLK = ~BUS_CLK;
    end

    int checks = 0;
    int errors = 0;

    // Source FIFO contents and gating.
    logic [31:0] fifo_q [$];
    logic        gate;
    logic        pop_flag;

    // Records accepted by the consumer: {extra, ts}.
    logic [71:0] got_q [$];

    // Record-level reference model.
    logic        m_have_lo, m_have_mid, m_pending;
    logic [23:0] m_lo, m_mid;
    logic [63:0] m_rec;
    logic [7:0]  m_ext;
    logic [15:0] m_id, m_seq;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_inputs();
        FIFO_EMPTY = gate || (fifo_q.size() == 0);
        FIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic step();
        @(posedge BUS_CLK);
        #1;
        if (pop_flag && fifo_q.size() != 0) void'(fifo_q.pop_front());
        set_inputs();
    endtask

    task automatic model_reset();
        m_have_lo = 0; m_have_mid = 0; m_pending = 0;
        m_lo = 0; m_mid = 0; m_rec = 0; m_ext = 0;
        m_id = 0; m_seq = 0;
    endtask

    task automatic model_drop_partial();
        if (m_seq != 16'hFFFF) m_seq++;
        m_have_lo = 0;
        m_have_mid = 0;
    endtask

    // One examined word, interpreted from the record format.
    task automatic model_word(input logic [31:0] w);
        if (w[31:28] != 4'h5) begin
            if (m_id != 16'hFFFF) m_id++;
        end else if (w[27:24] == 4'd0) begin
            if (m_have_lo && m_seq != 16'hFFFF) m_seq++;
            m_lo = w[23:0];
            m_have_lo = 1;
            m_have_mid = 0;
        end else if (w[27:24] == 4'd1 && m_have_lo && !m_have_mid) begin
            m_mid = w[23:0];
            m_have_mid = 1;
        end else if (w[27:24] == 4'd2 && m_have_mid) begin
            m_rec = {w[15:0], m_mid, m_lo};
            m_ext = w[23:16];
            m_pending = 1;
            m_have_lo = 0;
            m_have_mid = 0;
        end else begin
            model_drop_partial();
        end
    endtask

    // Compare process: checks outputs against the model, then advances the model.
    initial begin
        logic exp_read;
        model_reset();
        pop_flag = 0;
        forever begin
            @(negedge BUS_CLK);
            if (BUS_RST) begin
                model_reset();
                pop_flag = 0;
                chk("rst_valid", TS_VALID, 0);
                chk("rst_id_cnt", ID_ERR_CNT, 0);
                chk("rst_seq_cnt", SEQ_ERR_CNT, 0);
                chk("rst_ts_data", TS_DATA, 0);
                chk("rst_ts_extra", TS_EXTRA, 0);
            end else begin
                exp_read = !FIFO_EMPTY && (!m_pending || TS_READY);
                chk("fifo_read", FIFO_READ, exp_read);
                chk("ts_valid", TS_VALID, m_pending);
                if (m_pending) begin
                    chk("ts_data", TS_DATA, m_rec);
                    chk("ts_extra", TS_EXTRA, m_ext);
                end
                chk("id_err_cnt", ID_ERR_CNT, m_id);
                chk("seq_err_cnt", SEQ_ERR_CNT, m_seq);
                pop_flag = FIFO_READ;
                if (m_pending && TS_READY) begin
                    got_q.push_back({TS_EXTRA, TS_DATA});
                    m_pending = 0;
                end
                if (exp_read) model_word(FIFO_DATA);
                if (CLEAR_ERR) begin
                    m_id = 0;
                    m_seq = 0;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        BUS_RST = 0; TS_READY = 0; CLEAR_ERR = 0; gate = 1;
        set_inputs();
        #1 BUS_RST = 1;
        step(); step();
        BUS_RST = 0; gate = 0;
        set_inputs();
        #1;
        chk("reset_valid_lit", TS_VALID, 0);
        chk("reset_read_lit", FIFO_READ, 0);

        // Test 1: a single record with the consumer always ready.
        TS_READY = 1;
        fifo_q.push_back(32'h50123456); fifo_q.push_back(32'h51ABCDEF); fifo_q.push_back(32'h52A51122);
        set_inputs();
        step(); step();
        chk("t1_not_yet_valid", TS_VALID, 0);
        step();
        chk("t1_valid_lit", TS_VALID, 1);
        chk("t1_data_lit", TS_DATA, 64'h1122ABCDEF123456);
        chk("t1_extra_lit", TS_EXTRA, 8'hA5);
        step();
        chk("t1_valid_one_cycle", TS_VALID, 0);
        chk("t1_cnt_lit", {ID_ERR_CNT, SEQ_ERR_CNT}, 0);

        // Test 2: two records back-to-back, with the consumer stalled for 10 cycles.
        TS_READY = 0;
        fifo_q.push_back(32'h50CCCCCC); fifo_q.push_back(32'h51DDDDDD); fifo_q.push_back(32'h5201EEEE);
        fifo_q.push_back(32'h50123123); fifo_q.push_back(32'h51456456); fifo_q.push_back(32'h52FF7890);
        set_inputs();
        step(); step(); step();
        chk("t2_valid_lit", TS_VALID, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_hold_read_lit", FIFO_READ, 0);
            chk("t2_hold_data_lit", TS_DATA, 64'hEEEEDDDDDDCCCCCC);
        end
        TS_READY = 1;
        #1;
        chk("t2_same_cycle_read_lit", FIFO_READ, 1);
        step(); step();
        chk("t2_gap_lit", TS_VALID, 0);
        step();
        chk("t2_second_valid_lit", TS_VALID, 1);
        chk("t2_second_data_lit", TS_DATA, 64'h7890456456123123);
        step();

        // Test 3: sequence error (idx0, idx2, idx0, idx1, idx2).
        fifo_q.push_back(32'h50000001); fifo_q.push_back(32'h52000002);
        fifo_q.push_back(32'h50654321); fifo_q.push_back(32'h51FEDCBA); fifo_q.push_back(32'h52C30F0F);
        set_inputs();
        repeat (6) step();
        chk("t3_seq_lit", SEQ_ERR_CNT, 1);

        // Test 4: a foreign word between idx0 and idx1.
        fifo_q.push_back(32'h50111111); fifo_q.push_back(32'h30000000);
        fifo_q.push_back(32'h51222222); fifo_q.push_back(32'h52333333);
        set_inputs();
        repeat (5) step();
        chk("t4_id_lit", ID_ERR_CNT, 1);

        // Test 5: identifier counter saturation, then a clear that wins over an increment.
        for (int i = 0; i < 65540; i++) fifo_q.push_back(32'h30000000 | i);
        set_inputs();
        n = 0;
        while (fifo_q.size() != 0 && n < 70000) begin
            step();
            n++;
        end
        chk("t5_drain_bound", (n < 70000), 1);
        step();
        chk("t5_sat_lit", ID_ERR_CNT, 16'hFFFF);
        CLEAR_ERR = 1;
        fifo_q.push_back(32'h3FFFFFFF);
        set_inputs();
        step();
        CLEAR_ERR = 0;
        set_inputs();
        #1;
        chk("t5_clear_id_lit", ID_ERR_CNT, 0);
        chk("t5_clear_seq_lit", SEQ_ERR_CNT, 0);

        // Test 6: asynchronous reset after idx1, then a clean record.
        fifo_q.push_back(32'h30000000); fifo_q.push_back(32'h50AAAAAA); fifo_q.push_back(32'h51BBBBBB);
        set_inputs();
        repeat (3) step();
        chk("t6_pre_id_lit", ID_ERR_CNT, 1);
        #3;
        BUS_RST = 1; gate = 1;
        set_inputs();
        #1;
        chk("t6_async_valid_lit", TS_VALID, 0);
        chk("t6_async_id_lit", ID_ERR_CNT, 0);
        chk("t6_async_data_lit", TS_DATA, 0);
        step(); step();
        BUS_RST = 0; gate = 0;
        fifo_q.push_back(32'h50000010); fifo_q.push_back(32'h51000020); fifo_q.push_back(32'h52550030);
        set_inputs();
        step(); step(); step();
        chk("t6_valid_lit", TS_VALID, 1);
        chk("t6_data_lit", TS_DATA, 64'h0030000020000010);
        chk("t6_extra_lit", TS_EXTRA, 8'h55);
        step(); step();

        // Records accepted by the consumer, in order.
        chk("rec_count", got_q.size(), 6);
        if (got_q.size() == 6) begin
            chk("rec0", got_q[0], {8'hA5, 64'h1122ABCDEF123456});
            chk("rec1", got_q[1], {8'h01, 64'hEEEEDDDDDDCCCCCC});
            chk("rec2", got_q[2], {8'hFF, 64'h7890456456123123});
            chk("rec3", got_q[3], {8'hC3, 64'h0F0FFEDCBA654321});
            chk("rec4", got_q[4], {8'h33, 64'h3333222222111111});
            chk("rec5", got_q[5], {8'h55, 64'h0030000020000010});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timestamp_word_assembler.md
Name: timestamp_word_assembler

Overview:
- Downstream consumer of the timestamp_div FIFO word stream, the same FWFT interface bram_fifo reads.
- Pulls 32-bit tagged words and reassembles each 3-word hit record into one 64-bit timestamp plus an 8-bit extra field.
- Presents each record on a valid/ready output port for on-chip consumers such as trigger matching or a TLU comparator.
- Checks identifier and word sequence, and counts errors in saturating counters.

Parameters:
- IDENTIFIER, 4'b0101, expected value of word bits [31:28]; words with any other value are foreign.
- ERR_CNT_WIDTH, 16, width of each saturating error counter.

Ports:
- BUS_CLK  in  1  single clock for all logic.
- BUS_RST  in  1  asynchronous, active-high reset.
- FIFO_EMPTY  in  1  source has no word; FIFO_DATA is invalid.
- FIFO_DATA  in  32  current head word (first-word-fall-through).
- FIFO_READ  out  1  pops the head word; FIFO_DATA is consumed in the same cycle.
- TS_VALID  out  1  assembled record available.
- TS_READY  in  1  consumer accepts the record.
- TS_DATA  out  64  assembled timestamp.
- TS_EXTRA  out  8  extra field (fine phase).
- CLEAR_ERR  in  1  synchronous pulse; zeroes both error counters.
- ID_ERR_CNT  out  ERR_CNT_WIDTH  count of foreign-identifier words.
- SEQ_ERR_CNT  out  ERR_CNT_WIDTH  count of sequence violations.

Behaviour:
- Word format: [31:28] identifier, [27:24] index, [23:0] payload.
  - idx0 payload = TS[23:0].
  - idx1 payload = TS[47:24].
  - idx2 payload = {EXTRA[7:0], TS[63:48]}.
- Reset (async): state=WAIT0; TS_VALID=0; TS_DATA=0; TS_EXTRA=0; FIFO_READ=0; both counters=0.
- FIFO_READ is combinational: !FIFO_EMPTY && (state!=HOLD || TS_READY). A word is examined only in a cycle where FIFO_READ=1.
- States and transitions:
  - WAIT0:
    - idx0 -> latch TS[23:0], go WAIT1.
    - idx!=0 -> SEQ_ERR++, drop word, stay.
  - WAIT1:
    - idx1 -> latch TS[47:24], go WAIT2.
    - idx0 -> SEQ_ERR++, relatch as new idx0, stay WAIT1.
    - any other idx -> SEQ_ERR++, go WAIT0.
  - WAIT2:
    - idx2 -> latch TS[63:48] and EXTRA, go HOLD, TS_VALID=1 next cycle.
    - idx0 -> SEQ_ERR++, relatch, go WAIT1.
    - any other idx -> SEQ_ERR++, go WAIT0.
  - HOLD:
    - TS_VALID=1; TS_DATA and TS_EXTRA stable until TS_READY.
    - TS_READY=1 and a word available: handshake plus that word processed under WAIT0 rules in the same cycle, so back-to-back records lose no cycle.
    - TS_READY=1 and FIFO empty: go WAIT0, TS_VALID=0.
- Foreign identifier, any state: ID_ERR++, word dropped, state unchanged. In HOLD this applies only when TS_READY=1, since only then is the word read.
- Throughput: latency from the idx2 word popped to TS_VALID is 1 cycle; sustains 1 record per 3 words with no bubbles.
- Counters:
  - Saturate at all-ones; no wrap.
  - CLEAR_ERR takes priority over a same-cycle increment; the result is 0.
  - ID and SEQ increments never coincide, because exactly one word is examined per cycle.
- Reset mid-record: partial fields are discarded; the first word after reset is processed in WAIT0.
- TS_READY while TS_VALID=0 is ignored.

Test Plan:
- Three words 0x50123456, 0x51ABCDEF, 0x52A51122, FIFO never empty, TS_READY=1 -> TS_DATA=0x1122ABCDEF123456 and TS_EXTRA=0xA5, TS_VALID high 1 cycle, one cycle after idx2 popped; counters 0.
- Two records back-to-back with TS_READY held 0 for 10 cycles -> FIFO_READ=0 during hold, first record stable. On TS_READY=1 the second record's idx0 is popped in the same cycle; second TS_VALID appears 3 cycles later.
- Stream idx0, idx2, idx0, idx1, idx2 (identifier 5) -> SEQ_ERR_CNT=1 and one record built from the last three words.
- Word 0x30000000 between idx0 and idx1 -> ID_ERR_CNT=1 and the record still assembles correctly.
- 65540 foreign words, ERR_CNT_WIDTH=16 -> ID_ERR_CNT=0xFFFF. Then CLEAR_ERR together with one more foreign word -> 0.
- BUS_RST asserted asynchronously mid-cycle after idx1 -> TS_VALID and counters 0 immediately. A following full record assembles correctly, with no stale bits from the aborted record.
